// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC time-setting controller.
// Pure declarations; no latency or flow control of its own.
package rtc_pkg;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        SET_HR  = 3'd1,
        SET_MIN = 3'd2,
        SET_SEC = 3'd3,
        COMMIT  = 3'd4
    } rtc_set_state_t;

    localparam logic [7:0] HR_MAX_BCD = 8'h23;
    localparam logic [7:0] MS_MAX_BCD = 8'h59;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_HR   = 2'd1;
    localparam logic [1:0] SEL_MIN  = 2'd2;
    localparam logic [1:0] SEL_SEC  = 2'd3;

endpackage

// File: rtl/rtc_set_ctrl_bcd2_step.sv
// Two-digit BCD +/-1 with wrap at max; illegal input steps to 00. Combinational, zero latency.
// No flow control: inc and dec together (or neither) pass the value through unchanged.
module bcd2_step (
    input  logic [7:0] val,
    input  logic [7:0] max,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] nxt
);

    logic legal;

    // max is legal BCD, so a byte compare also bounds the tens digit
    assign legal = (val[3:0] <= 4'd9) && (val <= max);

    always_comb begin
        nxt = val;
        if (inc ^ dec) begin
            if (!legal) begin
                nxt = 8'h00;
            end else if (inc) begin
                if (val == max)              nxt = 8'h00;
                else if (val[3:0] == 4'd9)   nxt = {val[7:4] + 4'd1, 4'd0};
                else                         nxt = {val[7:4], val[3:0] + 4'd1};
            end else begin
                if (val == 8'h00)            nxt = max;
                else if (val[3:0] == 4'd0)   nxt = {val[7:4] - 4'd1, 4'd9};
                else                         nxt = {val[7:4], val[3:0] - 4'd1};
            end
        end
    end

endmodule

// File: rtl/rtc_set_ctrl.sv
// RTC time-set FSM: shadow edit of hh:mm:ss, one-cycle load on commit, idle timeout; all outputs registered, 1-cycle latency.
// No backpressure: pulses act on the cycle they arrive. Optional dec_p input enabled by `define RTC_SET_DEC_EN.
module rtc_set_ctrl
    import rtc_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 3000,
    parameter int BLINK_HALF    = 50,
    parameter int TMR_W         = 12
) (
    input  logic       hundred_clk,
    input  logic       rst,
    input  logic       mode_p,
    input  logic       inc_p,
`ifdef RTC_SET_DEC_EN
    input  logic       dec_p,
`endif
    input  logic [3:0] cur_hrm,
    input  logic [3:0] cur_hrl,
    input  logic [3:0] cur_minm,
    input  logic [3:0] cur_minl,
    input  logic [3:0] cur_secm,
    input  logic [3:0] cur_secl,
    output logic       run_en,
    output logic       load,
    output logic [3:0] ld_hrm,
    output logic [3:0] ld_hrl,
    output logic [3:0] ld_minm,
    output logic [3:0] ld_minl,
    output logic [3:0] ld_secm,
    output logic [3:0] ld_secl,
    output logic [1:0] sel,
    output logic       blink
);

    localparam logic [TMR_W-1:0] TMO_LAST   = TMR_W'(TIMEOUT_TICKS - 1);
    localparam logic [TMR_W-1:0] BLINK_LAST = TMR_W'(BLINK_HALF - 1);

    rtc_set_state_t   state;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] bcnt;
    logic [7:0]       fld;
    logic [7:0]       fld_max;
    logic [7:0]       fld_nxt;
    logic             dec_w;

`ifdef RTC_SET_DEC_EN
    assign dec_w = dec_p;
`else
    assign dec_w = 1'b0;
`endif

    // The ld_* registers double as the shadow copy being edited
    always_comb begin
        fld     = {ld_hrm, ld_hrl};
        fld_max = HR_MAX_BCD;
        case (state)
            SET_MIN: begin
                fld     = {ld_minm, ld_minl};
                fld_max = MS_MAX_BCD;
            end
            SET_SEC: begin
                fld     = {ld_secm, ld_secl};
                fld_max = MS_MAX_BCD;
            end
            default: ;
        endcase
    end

    bcd2_step u_step (
        .val (fld),
        .max (fld_max),
        .inc (inc_p),
        .dec (dec_w),
        .nxt (fld_nxt)
    );

    always_ff @(posedge hundred_clk) begin
        if (!rst) begin
            state  <= RUN;
            run_en <= 1'b1;
            load   <= 1'b0;
            sel    <= SEL_NONE;
            blink  <= 1'b0;
            tmr    <= '0;
            bcnt   <= '0;
            {ld_hrm, ld_hrl, ld_minm, ld_minl, ld_secm, ld_secl} <= '0;
        end else begin
            load <= 1'b0;
            case (state)
                RUN: begin
                    if (mode_p) begin
                        {ld_hrm, ld_hrl, ld_minm, ld_minl, ld_secm, ld_secl} <=
                            {cur_hrm, cur_hrl, cur_minm, cur_minl, cur_secm, cur_secl};
                        state  <= SET_HR;
                        sel    <= SEL_HR;
                        run_en <= 1'b0;
                        tmr    <= '0;
                        bcnt   <= '0;
                        blink  <= 1'b0;
                    end
                end
                SET_HR, SET_MIN, SET_SEC: begin
                    if (mode_p) begin
                        tmr   <= '0;
                        bcnt  <= '0;
                        blink <= 1'b0;
                        case (state)
                            SET_HR:  begin state <= SET_MIN; sel <= SEL_MIN; end
                            SET_MIN: begin state <= SET_SEC; sel <= SEL_SEC; end
                            default: begin state <= COMMIT; sel <= SEL_NONE; load <= 1'b1; end
                        endcase
                    end else if (inc_p || dec_w) begin
                        tmr   <= '0;
                        bcnt  <= '0;
                        blink <= 1'b0;
                        case (state)
                            SET_HR:  {ld_hrm, ld_hrl}   <= fld_nxt;
                            SET_MIN: {ld_minm, ld_minl} <= fld_nxt;
                            default: {ld_secm, ld_secl} <= fld_nxt;
                        endcase
                    end else if (tmr == TMO_LAST) begin
                        // Abandon the edit: shadows are left as-is but never loaded
                        state  <= RUN;
                        sel    <= SEL_NONE;
                        run_en <= 1'b1;
                        blink  <= 1'b0;
                        tmr    <= '0;
                        bcnt   <= '0;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                        if (bcnt == BLINK_LAST) begin
                            bcnt  <= '0;
                            blink <= ~blink;
                        end else begin
                            bcnt <= bcnt + TMR_W'(1);
                        end
                    end
                end
                COMMIT: begin
                    state  <= RUN;
                    run_en <= 1'b1;
                end
                default: begin
                    state  <= RUN;
                    sel    <= SEL_NONE;
                    run_en <= 1'b1;
                    blink  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// Scoreboard bench for rtc_set_ctrl: a decimal-arithmetic time-edit model predicts every cycle's outputs.
module tb_rtc_set_ctrl;

    localparam int TMO = 3000;
    localparam int BH  = 50;

    typedef struct packed {
        logic        run_en;
        logic        load;
        logic [1:0]  sel;
        logic        blink;
        logic [23:0] ld;
    } obs_t;

    logic       hundred_clk = 1'b0;
    logic       rst;
    logic       mode_p;
    logic       inc_p;
`ifdef RTC_SET_DEC_EN
    logic       dec_p;
`endif
    logic [3:0] curd [6];
    logic       run_en, load, blink;
    logic [1:0] sel;
    logic [3:0] ld_hrm, ld_hrl, ld_minm, ld_minl, ld_secm, ld_secl;

    int   n_cmp = 0;
    int   n_bad = 0;
    obs_t exp_q[$];

    // Reference model: 0 run, 1..3 editing hours/minutes/seconds, 4 commit
    int mst;
    int idle;
    int sh [6];
    int cur_nx [6];

    rtc_set_ctrl dut (
        .hundred_clk (hundred_clk),
        .rst         (rst),
        .mode_p      (mode_p),
        .inc_p       (inc_p),
`ifdef RTC_SET_DEC_EN
        .dec_p       (dec_p),
`endif
        .cur_hrm     (curd[0]),
        .cur_hrl     (curd[1]),
        .cur_minm    (curd[2]),
        .cur_minl    (curd[3]),
        .cur_secm    (curd[4]),
        .cur_secl    (curd[5]),
        .run_en      (run_en),
        .load        (load),
        .ld_hrm      (ld_hrm),
        .ld_hrl      (ld_hrl),
        .ld_minm     (ld_minm),
        .ld_minl     (ld_minl),
        .ld_secm     (ld_secm),
        .ld_secl     (ld_secl),
        .sel         (sel),
        .blink       (blink)
    );

    initial begin
        forever #5 hundred_clk = ~hundred_clk;
    end

    function automatic void fld_step(input int f, input bit up);
        int mx;
        int v;
        mx = (f == 0) ? 23 : 59;
        v  = sh[2*f] * 10 + sh[2*f+1];
        if (sh[2*f] > 9 || sh[2*f+1] > 9 || v > mx) v = 0;
        else if (up) v = (v == mx) ? 0 : v + 1;
        else         v = (v == 0) ? mx : v - 1;
        sh[2*f]   = v / 10;
        sh[2*f+1] = v % 10;
    endfunction

    function automatic void model_step(input bit r, input bit m, input bit i, input bit d);
        if (!r) begin
            mst  = 0;
            idle = 0;
            for (int k = 0; k < 6; k++) sh[k] = 0;
        end else if (mst == 0) begin
            if (m) begin
                for (int k = 0; k < 6; k++) sh[k] = int'(curd[k]);
                mst  = 1;
                idle = 0;
            end
        end else if (mst <= 3) begin
            if (m) begin
                mst  = mst + 1;
                idle = 0;
            end else if (i || d) begin
                idle = 0;
                if (i != d) fld_step(mst - 1, i);
            end else if (idle == TMO - 1) begin
                mst  = 0;
                idle = 0;
            end else begin
                idle = idle + 1;
            end
        end else begin
            mst = 0;
        end
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        bit   in_set;
        in_set   = (mst >= 1) && (mst <= 3);
        o.run_en = (mst == 0);
        o.load   = (mst == 4);
        o.sel    = in_set ? 2'(mst) : 2'd0;
        o.blink  = in_set && (((idle / BH) % 2) == 1);
        for (int k = 0; k < 6; k++) o.ld[23 - 4*k -: 4] = 4'(sh[k]);
        return o;
    endfunction

    task automatic cyc(input bit r, input bit m, input bit i, input bit d);
        @(negedge hundred_clk);
        for (int k = 0; k < 6; k++) curd[k] = 4'(cur_nx[k]);
        rst    = r;
        mode_p = m;
        inc_p  = i;
`ifdef RTC_SET_DEC_EN
        dec_p  = d;
        model_step(r, m, i, d);
`else
        model_step(r, m, i, 1'b0 & d);
`endif
        exp_q.push_back(model_out());
    endtask

    task automatic idle_n(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_cur(input int a, input int b, input int c, input int d, input int e, input int f);
        cur_nx[0] = a; cur_nx[1] = b; cur_nx[2] = c;
        cur_nx[3] = d; cur_nx[4] = e; cur_nx[5] = f;
    endtask

    // Monitor: outputs are registered, so every cycle presents a response to score
    initial begin
        obs_t e;
        obs_t got;
        forever begin
            @(posedge hundred_clk);
            #1;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                got = {run_en, load, sel, blink, ld_hrm, ld_hrl, ld_minm, ld_minl, ld_secm, ld_secl};
                n_cmp++;
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL outputs t=%0t got run_en=%b load=%b sel=%0d blink=%b ld=%h required run_en=%b load=%b sel=%0d blink=%b ld=%h",
                             $time, got.run_en, got.load, got.sel, got.blink, got.ld,
                             e.run_en, e.load, e.sel, e.blink, e.ld);
                end
            end
        end
    end

    initial begin
        bit r, m, i, d;
        rst    = 1'b0;
        mode_p = 1'b0;
        inc_p  = 1'b0;
`ifdef RTC_SET_DEC_EN
        dec_p  = 1'b0;
`endif
        mst  = 0;
        idle = 0;
        for (int k = 0; k < 6; k++) sh[k] = 0;
        set_cur(1, 2, 3, 4, 5, 6);
        for (int k = 0; k < 6; k++) curd[k] = 4'(cur_nx[k]);

        // Reset, capture 12:34:56, hours 12 -> 15, full commit
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        idle_n(2);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle_n(3);

        // Hours 22 -> 23 -> 00, then idle timeout in the minutes field
        set_cur(2, 2, 5, 9, 0, 7);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle_n(TMO + 5);

        // mode+inc together in hours, blink over 120 ticks, minutes 59 -> 00, commit
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        idle_n(120);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle_n(2);

        // Illegal captured hours 2A forced to 00; seconds at 00 for the decrement case
        set_cur(2, 10, 4, 1, 0, 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        idle_n(60);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        idle_n(10);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle_n(2);

        // Reset in the middle of an edit
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        idle_n(2);

        // Randomized pulses, occasional resets and arbitrary (sometimes illegal) live time
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                for (int k = 0; k < 6; k++)
                    cur_nx[k] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15))
                                                            : int'($urandom_range(0, 9));
            end
            r = ($urandom_range(0, 299) != 0);
            m = ($urandom_range(0, 11) == 0);
            i = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 3) == 0);
            cyc(r, m, i, d);
        end
        idle_n(2);

        @(posedge hundred_clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
